// File: rtl/bk_adder.sv
// ---------------------------------------------------------------------------
// bk_adder
//   16-bit Brent-Kung parallel-prefix adder with a registered result.
//   Carry-in is fixed at 0. A new operand pair is accepted every cycle, and
//   its result appears one clock later.
//
// Ports
//   clk    in   1   rising-edge clock
//   rst_n  in   1   asynchronous active-low reset (clears sum/cout)
//   a      in  16   operand A, unsigned
//   b      in  16   operand B, unsigned
//   sum    out 16   registered (a + b) mod 2^16
//   cout   out  1   registered carry-out of bit 15
// ---------------------------------------------------------------------------
module bk_adder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum,
  output logic        cout
);

  localparam int N      = 16;
  localparam int LG     = 4;            // log2(N)
  localparam int LEVELS = 2 * LG - 1;   // 4 up-sweep + 3 down-sweep

  // Group generate/propagate per prefix level. Level 0 holds the bit-level
  // g/p. At every level, node i holds the group (G,P) that ends at bit i.
  logic [LEVELS:0][N-1:0] g_lvl;
  logic [LEVELS:0][N-1:0] p_lvl;

  logic [N-1:0] sum_next;
  logic         cout_next;

  genvar gi, li;

  // Bit-level pre-processing
  generate
    for (gi = 0; gi < N; gi++) begin : g_pre
      assign g_lvl[0][gi] = a[gi] & b[gi];
      assign p_lvl[0][gi] = a[gi] ^ b[gi];
    end
  endgenerate

  // Up-sweep: at span s, every node whose index+1 is a multiple of 2s
  // absorbs the group that ends s bits lower. After level LG, nodes
  // 1, 3, 7 and 15 hold full prefixes starting at bit 0.
  generate
    for (li = 1; li <= LG; li++) begin : g_up
      localparam int S = 1 << (li - 1);
      for (gi = 0; gi < N; gi++) begin : g_node
        if (((gi + 1) % (2 * S)) == 0) begin : g_comb
          assign g_lvl[li][gi] = g_lvl[li-1][gi] |
                                 (p_lvl[li-1][gi] & g_lvl[li-1][gi-S]);
          assign p_lvl[li][gi] = p_lvl[li-1][gi] & p_lvl[li-1][gi-S];
        end else begin : g_pass
          assign g_lvl[li][gi] = g_lvl[li-1][gi];
          assign p_lvl[li][gi] = p_lvl[li-1][gi];
        end
      end
    end
  endgenerate

  // Down-sweep: spans 4, 2, 1. A node whose index+1 is an odd multiple of s
  // (and lies above the first complete block) extends its partial group
  // down to bit 0 using the finished prefix s bits below it. Span 4 fills
  // [11:0]; span 2 fills [5:0], [9:0], [13:0]; span 1 fills the even nodes.
  generate
    for (li = 1; li < LG; li++) begin : g_down
      localparam int S  = 1 << (LG - 1 - li);
      localparam int LV = LG + li;
      for (gi = 0; gi < N; gi++) begin : g_node
        if ((((gi + 1) % (2 * S)) == S) && ((gi + 1) > 2 * S)) begin : g_comb
          assign g_lvl[LV][gi] = g_lvl[LV-1][gi] |
                                 (p_lvl[LV-1][gi] & g_lvl[LV-1][gi-S]);
          assign p_lvl[LV][gi] = p_lvl[LV-1][gi] & p_lvl[LV-1][gi-S];
        end else begin : g_pass
          assign g_lvl[LV][gi] = g_lvl[LV-1][gi];
          assign p_lvl[LV][gi] = p_lvl[LV-1][gi];
        end
      end
    end
  endgenerate

  // Sum: g_lvl[LEVELS][i] is the carry into bit i+1.
  assign sum_next[0] = p_lvl[0][0];
  generate
    for (gi = 1; gi < N; gi++) begin : g_sum
      assign sum_next[gi] = p_lvl[0][gi] ^ g_lvl[LEVELS][gi-1];
    end
  endgenerate
  assign cout_next = g_lvl[LEVELS][N-1];

  // Result register. Reset clears the outputs at once and discards any
  // in-flight result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum  <= '0;
      cout <= 1'b0;
    end else begin
      sum  <= sum_next;
      cout <= cout_next;
    end
  end

endmodule

// File: tb/tb_bk_adder.sv
// ---------------------------------------------------------------------------
// tb_bk_adder
//   Scoreboard bench for bk_adder. The driver applies operands on the falling
//   edge and pushes the reference 17-bit sum into a queue. The monitor pops
//   one entry per rising edge (sampled 1 time unit later) while out of reset.
// ---------------------------------------------------------------------------
module tb_bk_adder;

  logic        clk;
  logic        rst_n;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] sum;
  logic        cout;

  logic [16:0] exp_q[$];
  int          n_cmp;
  int          n_err;
  logic        done;

  bk_adder dut (
    .clk  (clk),
    .rst_n(rst_n),
    .a    (a),
    .b    (b),
    .sum  (sum),
    .cout (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [16:0] act, input logic [16:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got cout=%0b sum=%04h, expected cout=%0b sum=%04h",
               name, act[16], act[15:0], req[16], req[15:0]);
    end
  endtask

  // Apply one operand pair; its result is expected after the next rising edge.
  task automatic send(input logic [15:0] x, input logic [15:0] y);
    @(negedge clk);
    a = x;
    b = y;
    exp_q.push_back({1'b0, x} + {1'b0, y});
  endtask

  // Monitor / scoreboard
  initial begin
    logic [16:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("scoreboard", {cout, sum}, e);
        $display("txn a=%04h b=%04h -> cout=%0b sum=%04h (exp %0b %04h)",
                 a, b, cout, sum, e[16], e[15:0]);
      end
    end
  end

  initial begin
    logic [15:0] t1, t2;
    n_cmp = 0;
    n_err = 0;
    done  = 1'b0;
    rst_n = 1'b0;
    a     = 16'h0000;
    b     = 16'h0000;

    // Reset state
    #1;
    check("reset_state", {cout, sum}, 17'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Small operands
    send(16'h0001, 16'h0001);
    send(16'h000F, 16'h000F);
    send(16'h00F0, 16'h00F0);

    // Full-carry chains and mixed high patterns
    send(16'hFFFF, 16'hFFFF);
    send(16'hFFFF, 16'h0001);
    send(16'h0001, 16'hFFFF);
    send(16'hFEEF, 16'hFEEF);
    send(16'hF1EF, 16'hF1EF);
    send(16'hFFEE, 16'hFFEE);
    send(16'h8000, 16'h8000);
    send(16'h0000, 16'h0000);

    // Sweeps
    for (int n = 1; n <= 30; n++) send(16'(n), 16'(n));
    for (int n = 16'h10; n <= 16'hF0; n += 16'h10) send(16'(n), 16'(n));

    // Operand changes between edges must not reach the outputs
    send(16'h1234, 16'h4321);
    @(posedge clk);
    #3;
    a = 16'hFFFF;
    b = 16'hFFFF;
    #1;
    check("mid_cycle_hold", {cout, sum}, 17'h05555);

    // Reset asserted mid-stream
    send(16'hFFFF, 16'hFFFF);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_immediate", {cout, sum}, 17'h0);
    @(negedge clk);
    a = 16'h0110;
    b = 16'h0110;
    @(posedge clk);
    #1;
    check("reset_held", {cout, sum}, 17'h0);
    @(negedge clk);
    check("reset_held2", {cout, sum}, 17'h0);
    rst_n = 1'b1;
    exp_q.push_back(17'h00220);

    // Random
    for (int i = 0; i < 10000; i++) begin
      t1 = 16'($urandom);
      t2 = 16'($urandom);
      send(t1, t2);
    end

    repeat (3) @(negedge clk);
    check("queue_drained", 17'(exp_q.size()), 17'h0);
    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time bound
  initial begin
    #2000000;
    if (!done) begin
      $display("FAIL timeout: got no completion, expected completion before limit");
      $fatal(1, "timeout");
    end
  end

endmodule
